rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
- Shares the register file's single synchronous write port (regwrite / write_reg / write_data) between two producers.
  - Producer A: the in-order pipeline writeback stage (WB). It cannot be back-pressured directly.
  - Producer B: a long-latency unit (MDU / load-miss return) using valid/ready.
- Buffers B results in a small FIFO and gives WB priority.
- Asserts a pipeline stall to drain B when B starves.
- Exports a pending-destination mask so hazard logic can protect against write-after-write reordering.

Parameters:
- FIFO_DEPTH, 2, B-side result FIFO entries (power of two, >=2)
- STARVE_MAX, 4, consecutive cycles a non-empty FIFO may go ungranted before a forced drain (1..15)

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- wb_valid  in  1  WB has a result this cycle
- wb_rd  in  5  WB destination register
- wb_data  in  32  WB result
- lu_valid  in  1  B offers a result
- lu_ready  out  1  B result accepted this cycle (= FIFO not full)
- lu_rd  in  5  B destination register
- lu_data  in  32  B result
- regwrite  out  1  register file write enable
- write_reg  out  5  register file rd
- write_data  out  32  register file write data
- stall_req  out  1  pipeline must hold the WB stage and all upstream stages this cycle
- pending_mask  out  32  bit r set while any FIFO entry targets register r; bit 0 is always 0

Behaviour:
- Reset values (asynchronous):
  - FIFO empty.
  - Starve counter 0.
  - FSM in NORMAL.
  - lu_ready = 1 once reset deasserts.
  - regwrite = 0, write_reg = 0, write_data = 0, stall_req = 0, pending_mask = 0.
- Outputs regwrite / write_reg / write_data are combinational from the grant decision. When regwrite = 0, write_reg and write_data are driven to 0.
- x0 handling:
  - WB with wb_rd = 0: never produces a write.
  - B handshake with lu_rd = 0: completes (consumed) but is not enqueued.
- Enqueue: on lu_valid & lu_ready & lu_rd != 0.
  - No bypass; minimum B-to-write latency is 1 cycle.
  - lu_ready depends only on the registered full flag. When the FIFO is full, a pop in the same cycle does not admit a push.
- FSM NORMAL:
  - If wb_valid & wb_rd != 0: grant WB; the FIFO head waits.
  - Otherwise, if the FIFO is non-empty: grant the head and pop it.
  - stall_req = 0.
- Starve counter:
  - Increments each cycle the FIFO is non-empty and not popped.
  - Clears on any pop or when the FIFO is empty.
  - When the counter equals STARVE_MAX at a clock edge, go to DRAIN and clear the counter.
- FSM DRAIN:
  - stall_req = 1.
  - Grant the FIFO head regardless of wb_valid. The WB request is not written; the pipeline re-presents it next cycle.
  - Pop one entry, then return to NORMAL.
  - Exactly one stall cycle per drain.
- Starvation rule: a full FIFO with the FIFO non-empty also enters DRAIN on the next edge (lu_valid held while full counts as starvation).
- pending_mask: OR of one-hot(rd) over valid FIFO entries, from registered FIFO state.
  - The entry popped this cycle remains in the mask until the edge.
  - Hazard logic stalls any WB/issue whose rd hits the mask.
- Pointers wrap modulo FIFO_DEPTH. Full/empty are distinguished by an extra pointer bit.
- Reset mid-operation discards all queued B results. B is responsible for its own replay.

Optional Feature:
- Macro RF_ARB_STATS_EN.
- Defined:
  - Adds 32-bit output ports conflict_cnt (cycles with WB granted while the FIFO is non-empty) and drain_cnt (DRAIN entries).
  - Both saturate at 0xFFFFFFFF and clear on reset.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - REG_W = 5 and XLEN = 32.
  - FSM state encoding (ARB_NORMAL = 1'b0, ARB_DRAIN = 1'b1).
  - The FIFO entry struct {rd, data}.
- One sub-module, rf_arb_fifo: synchronous FIFO with full/empty, a registered entry array, and a per-entry valid vector used to build pending_mask.

Test Plan:
- Reset held, then released with all inputs 0 -> all outputs 0, lu_ready = 1, pending_mask = 0.
- wb_valid = 1, wb_rd = 5, wb_data = 0xDEADBEEF; no B -> same cycle: regwrite = 1, write_reg = 5, write_data = 0xDEADBEEF.
- B pushes rd = 7, data = 0x11 while WB idle -> next cycle: pending_mask = 0x80 and write of x7 = 0x11; the cycle after: mask = 0.
- B pushes rd = 3 and rd = 4 while wb_valid is held continuously -> lu_ready = 0 when full; stall_req = 1 for one cycle with x3 written; a later drain writes x4; WB writes are suppressed in the stall cycles.
- B pushes rd = 0 -> lu_ready handshake completes; no enqueue, no write, mask unchanged.
- Reset asserted with 2 entries queued -> the FIFO is cleared asynchronously, mask = 0, no write of the queued data after release.

Source files
------------

// File: rtl/rf_write_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter:
// datapath widths, arbiter FSM states and the B-side FIFO entry.
package rf_write_arbiter_pkg;

    localparam int REG_W = 5;
    localparam int XLEN  = 32;

    typedef enum logic {
        ARB_NORMAL = 1'b0,
        ARB_DRAIN  = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic [XLEN-1:0]  data;
    } arb_entry_t;

endpackage

// File: rtl/rf_write_arbiter_fifo.sv
// Result FIFO for the long-latency producer; also builds the
// mask of destination registers that still have a queued write.
module rf_arb_fifo
    import rf_write_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  arb_entry_t       push_entry,
    input  logic             pop,
    output arb_entry_t       head,
    output logic             full,
    output logic             empty,
    output logic [XLEN-1:0]  rd_mask
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [DEPTH-1:0] valid;
    arb_entry_t       mem [DEPTH];

    // Extra pointer bit tells full from empty when indices match
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
    assign head  = mem[rptr[AW-1:0]];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push && !full) begin
                mem[wptr[AW-1:0]]   <= push_entry;
                valid[wptr[AW-1:0]] <= 1'b1;
                wptr                <= wptr + 1'b1;
            end
            if (pop && !empty) begin
                valid[rptr[AW-1:0]] <= 1'b0;
                rptr                <= rptr + 1'b1;
            end
        end
    end

    always_comb begin
        rd_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i]) begin
                rd_mask[mem[i].rd] = 1'b1;
            end
        end
        rd_mask[0] = 1'b0;
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between WB and a long-latency unit.
// Optional statistics counters are enabled with RF_ARB_STATS_EN.
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wb_valid,
    input  logic [REG_W-1:0] wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             lu_valid,
    output logic             lu_ready,
    input  logic [REG_W-1:0] lu_rd,
    input  logic [XLEN-1:0]  lu_data,
    output logic             regwrite,
    output logic [REG_W-1:0] write_reg,
    output logic [XLEN-1:0]  write_data,
    output logic             stall_req,
    output logic [XLEN-1:0]  pending_mask
`ifdef RF_ARB_STATS_EN
    ,
    output logic [31:0]      conflict_cnt,
    output logic [31:0]      drain_cnt
`endif
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    arb_state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       wb_req;
    logic       push;
    logic       pop;
    logic       grant_wb;
    logic       go_drain;
    logic       full;
    logic       empty;
    arb_entry_t head;
    arb_entry_t push_entry;

    assign wb_req     = wb_valid && (wb_rd != '0);
    assign lu_ready   = !full;
    assign push       = lu_valid && !full && (lu_rd != '0);
    assign push_entry = '{rd: lu_rd, data: lu_data};

    rf_arb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .rd_mask    (pending_mask)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ARB_NORMAL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_wb  = 1'b0;
        pop       = 1'b0;
        stall_req = 1'b0;
        go_drain  = 1'b0;
        unique case (state_q)
            ARB_NORMAL: begin
                if (wb_req) begin
                    grant_wb = 1'b1;
                end else if (!empty) begin
                    pop = 1'b1;
                end
                // A full FIFO blocks B outright, so drain at once
                if (!empty && !pop &&
                    (cnt_q == STARVE_LIM || full)) begin
                    go_drain = 1'b1;
                    state_d  = ARB_DRAIN;
                end
            end
            ARB_DRAIN: begin
                stall_req = 1'b1;
                pop       = !empty;
                state_d   = ARB_NORMAL;
            end
            default: state_d = ARB_NORMAL;
        endcase
        if (empty || pop || go_drain) begin
            cnt_d = '0;
        end else if (cnt_q == STARVE_LIM) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_comb begin
        regwrite   = grant_wb || pop;
        write_reg  = '0;
        write_data = '0;
        if (grant_wb) begin
            write_reg  = wb_rd;
            write_data = wb_data;
        end else if (pop) begin
            write_reg  = head.rd;
            write_data = head.data;
        end
    end

`ifdef RF_ARB_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            conflict_cnt <= '0;
            drain_cnt    <= '0;
        end else begin
            if (grant_wb && !empty && conflict_cnt != '1) begin
                conflict_cnt <= conflict_cnt + 32'd1;
            end
            if (go_drain && drain_cnt != '1) begin
                drain_cnt <= drain_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: queued B results are
// expected back in order, WB writes are checked against live inputs.
module tb_rf_write_arbiter;
    import rf_write_arbiter_pkg::*;

    logic             clock = 1'b0;
    logic             reset;
    logic             wb_valid;
    logic [REG_W-1:0] wb_rd;
    logic [XLEN-1:0]  wb_data;
    logic             lu_valid;
    logic             lu_ready;
    logic [REG_W-1:0] lu_rd;
    logic [XLEN-1:0]  lu_data;
    logic             regwrite;
    logic [REG_W-1:0] write_reg;
    logic [XLEN-1:0]  write_data;
    logic             stall_req;
    logic [XLEN-1:0]  pending_mask;
`ifdef RF_ARB_STATS_EN
    logic [31:0]      conflict_cnt;
    logic [31:0]      drain_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;
    arb_entry_t sb[$];
    bit seen;

    always #5 clock = ~clock;

    rf_write_arbiter #(
        .FIFO_DEPTH (2),
        .STARVE_MAX (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .lu_valid     (lu_valid),
        .lu_ready     (lu_ready),
        .lu_rd        (lu_rd),
        .lu_data      (lu_data),
        .regwrite     (regwrite),
        .write_reg    (write_reg),
        .write_data   (write_data),
        .stall_req    (stall_req),
        .pending_mask (pending_mask)
`ifdef RF_ARB_STATS_EN
        ,
        .conflict_cnt (conflict_cnt),
        .drain_cnt    (drain_cnt)
`endif
    );

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic lu_push(input logic [4:0] rd, input logic [31:0] d);
        lu_valid = 1'b1;
        lu_rd    = rd;
        lu_data  = d;
        if (rd != 5'd0) sb.push_back('{rd: rd, data: d});
    endtask

    // Write-port monitor
    always @(negedge clock) begin
        arb_entry_t e;
        if (!reset) begin
            if (wb_valid && wb_rd != 5'd0 && !stall_req) begin
                check("wb_we", regwrite, 1);
                check("wb_rd", write_reg, wb_rd);
                check("wb_data", write_data, wb_data);
            end else if (regwrite) begin
                if (sb.size() == 0) begin
                    check("unexpected_write", regwrite, 0);
                end else begin
                    e = sb.pop_front();
                    check("lu_rd", write_reg, e.rd);
                    check("lu_data", write_data, e.data);
                end
            end else begin
                check("idle_port", {write_reg, write_data}, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        wb_valid = 1'b0;
        wb_rd    = '0;
        wb_data  = '0;
        lu_valid = 1'b0;
        lu_rd    = '0;
        lu_data  = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_regwrite", regwrite, 0);
        check("rst_write_reg", write_reg, 0);
        check("rst_write_data", write_data, 0);
        check("rst_stall", stall_req, 0);
        check("rst_mask", pending_mask, 0);
        check("rst_lu_ready", lu_ready, 1);

        // WB write, same cycle
        next_cycle();
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
        @(negedge clock);
        check("wb5_we", regwrite, 1);
        check("wb5_rd", write_reg, 5);
        check("wb5_data", write_data, 32'hDEADBEEF);

        // B result with WB idle: written one cycle later
        next_cycle();
        wb_valid = 1'b0;
        lu_push(5'd7, 32'h11);
        @(negedge clock);
        check("b7_ready", lu_ready, 1);
        check("b7_no_bypass", regwrite, 0);
        check("b7_mask0", pending_mask, 0);
        next_cycle();
        lu_valid = 1'b0;
        @(negedge clock);
        check("b7_mask", pending_mask, 32'h80);
        check("b7_we", regwrite, 1);
        next_cycle();
        @(negedge clock);
        check("b7_mask_clr", pending_mask, 0);
        check("b7_idle", regwrite, 0);

        // B fills FIFO while WB is busy every cycle
        next_cycle();
        wb_valid = 1'b1; wb_rd = 5'd10; wb_data = 32'hA0A0;
        lu_push(5'd3, 32'h33);
        @(negedge clock);
        check("f1_ready", lu_ready, 1);
        check("f1_stall", stall_req, 0);
        next_cycle();
        lu_push(5'd4, 32'h44);
        @(negedge clock);
        check("f2_ready", lu_ready, 1);
        check("f2_mask", pending_mask, 32'h08);
        next_cycle();
        lu_valid = 1'b0;
        @(negedge clock);
        check("full_ready", lu_ready, 0);
        check("full_mask", pending_mask, 32'h18);
        check("full_stall", stall_req, 0);
        next_cycle();
        @(negedge clock);
        check("drain1_stall", stall_req, 1);
        check("drain1_rd", write_reg, 3);
        next_cycle();
        @(negedge clock);
        check("drain1_once", stall_req, 0);
        check("post_drain_ready", lu_ready, 1);
        check("post_drain_mask", pending_mask, 32'h10);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            next_cycle();
            @(negedge clock);
            seen = stall_req;
        end
        check("drain2_seen", seen, 1);
        check("drain2_rd", write_reg, 4);
        next_cycle();
        @(negedge clock);
        check("drain2_once", stall_req, 0);
        next_cycle();
        wb_valid = 1'b0;
        @(negedge clock);
        check("drained_mask", pending_mask, 0);

        // x0 from B: handshake only
        next_cycle();
        lu_push(5'd0, 32'h99);
        @(negedge clock);
        check("x0_ready", lu_ready, 1);
        next_cycle();
        lu_valid = 1'b0;
        @(negedge clock);
        check("x0_no_write", regwrite, 0);
        check("x0_mask", pending_mask, 0);

        // Reset with two queued entries
        next_cycle();
        wb_valid = 1'b1; wb_rd = 5'd10; wb_data = 32'h5555;
        lu_push(5'd12, 32'hC);
        next_cycle();
        lu_push(5'd13, 32'hD);
        next_cycle();
        lu_valid = 1'b0;
        @(negedge clock);
        check("rq_mask", pending_mask, 32'h3000);
        #1;
        reset    = 1'b1;
        wb_valid = 1'b0;
        sb.delete();
        #1;
        check("rq_rst_mask", pending_mask, 0);
        check("rq_rst_we", regwrite, 0);
        next_cycle();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check("rq_no_write", regwrite, 0);
            check("rq_ready", lu_ready, 1);
            next_cycle();
        end
        check("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
